// File: rtl/vga_pkg.sv
// Shared definitions for the VGA link: 640x480 timing, pixel type and receiver states.
package vga_pkg;

  localparam int unsigned PIXEL_BITS = 4;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef struct packed {
    logic [PIXEL_BITS-1:0] r;
    logic [PIXEL_BITS-1:0] g;
    logic [PIXEL_BITS-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Input register stage for colour and both active-low syncs, plus falling-edge detect.
module vga_sync_edge
  import vga_pkg::*;
#(
  parameter int unsigned DATA_BITS = 3 * PIXEL_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 h_sync,
  input  logic                 v_sync,
  output logic [DATA_BITS-1:0] data_dly,
  output logic                 hs_fall,
  output logic                 vs_fall
);

  logic [DATA_BITS-1:0] data_q;
  logic                 hs_q, hs_d, vs_q, vs_d;

  // Colour is delayed alongside the previous-sync stage so a sample taken on
  // the pixel strobe belongs to the pixel the x counter currently names.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      data_dly <= '0;
      hs_q     <= 1'b0;
      hs_d     <= 1'b0;
      vs_q     <= 1'b0;
      vs_d     <= 1'b0;
    end else begin
      data_q   <= data;
      data_dly <= data_q;
      hs_q     <= h_sync;
      hs_d     <= hs_q;
      vs_q     <= v_sync;
      vs_d     <= vs_q;
    end
  end

  assign hs_fall = hs_d & ~hs_q;
  assign vs_fall = vs_d & ~vs_q;

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: rebuilds pixel/line counters from sync edges, locks on good timing, writes frame RAM.
// Optional VGA_RX_DECIMATE_EN: store only even x on even y into a quarter-size buffer.
module vga_rx
  import vga_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = vga_pkg::PIXEL_BITS,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT    = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK     = vga_pkg::H_BACK,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT    = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK     = vga_pkg::V_BACK,
`ifdef VGA_RX_DECIMATE_EN
  parameter int unsigned ADDR_BITS  = $clog2(H_ACTIVE * V_ACTIVE / 4)
`else
  parameter int unsigned ADDR_BITS  = $clog2(H_ACTIVE * V_ACTIVE)
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIXEL_BITS-1:0]   vga_r,
  input  logic [PIXEL_BITS-1:0]   vga_g,
  input  logic [PIXEL_BITS-1:0]   vga_b,
  input  logic                    h_sync,
  input  logic                    v_sync,
  output logic                    wr_en,
  output logic [ADDR_BITS-1:0]    wr_addr,
  output logic [3*PIXEL_BITS-1:0] wr_data,
  output logic                    frame_start,
  output logic                    locked,
  output logic [7:0]              err_count,
  output logic [9:0]              pix_x,
  output logic [9:0]              pix_y
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_OFF    = H_SYNC + H_BACK;
  localparam int unsigned V_OFF    = V_SYNC + V_BACK;
  localparam int unsigned DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [3*PIXEL_BITS-1:0] colour;
  logic                    hs_fall, vs_fall;
  logic [DIV_BITS-1:0]     div;
  logic [9:0]              x, y, ax, ay;
  logic                    vs_pend, seen_strobe, all_good;
  logic                    strobe, y_clear, line_good, frame_good, timeout;
  logic                    active, keep, lose;
  logic [ADDR_BITS-1:0]    addr;
  rx_state_t               state, state_next;

  vga_sync_edge #(.DATA_BITS(3 * PIXEL_BITS)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     ({vga_r, vga_g, vga_b}),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .data_dly (colour),
    .hs_fall  (hs_fall),
    .vs_fall  (vs_fall)
  );

  // A strobe coinciding with hs_fall is dropped: the line restarts instead.
  assign strobe     = (div == DIV_BITS'(CLK_DIV - 1)) && !hs_fall;
  assign y_clear    = hs_fall && (vs_pend || vs_fall);
  assign line_good  = (x == 10'(H_TOTAL - 1)) && seen_strobe;
  assign frame_good = (y == 10'(V_TOTAL - 1));
  assign timeout    = (x == 10'(H_TOTAL));

  always_comb begin
    ax     = x - 10'(H_OFF);
    ay     = y - 10'(V_OFF);
    active = (x >= 10'(H_OFF)) && (x < 10'(H_OFF + H_ACTIVE)) &&
             (y >= 10'(V_OFF)) && (y < 10'(V_OFF + V_ACTIVE));
`ifdef VGA_RX_DECIMATE_EN
    keep   = !ax[0] && !ay[0];
    addr   = ADDR_BITS'(32'(ay >> 1) * (H_ACTIVE / 2) + 32'(ax >> 1));
`else
    keep   = 1'b1;
    addr   = ADDR_BITS'(32'(ay) * H_ACTIVE + 32'(ax));
`endif
  end

  always_comb begin
    state_next = state;
    lose       = 1'b0;
    case (state)
      SEARCH:  if (y_clear) state_next = MEASURE;
      MEASURE: if (y_clear && all_good && line_good && frame_good) state_next = LOCKED;
      LOCKED: begin
        if (timeout || (hs_fall && !line_good) || (y_clear && !frame_good)) begin
          state_next = SEARCH;
          lose       = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      div         <= '0;
      x           <= '0;
      y           <= '0;
      vs_pend     <= 1'b0;
      seen_strobe <= 1'b0;
      all_good    <= 1'b1;
      err_count   <= '0;
      frame_start <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      state <= state_next;

      if (hs_fall || div == DIV_BITS'(CLK_DIV - 1)) div <= '0;
      else                                          div <= div + 1'b1;

      if (hs_fall)                 x <= '0;
      else if (strobe && x != '1)  x <= x + 10'd1;

      if (hs_fall)     seen_strobe <= 1'b0;
      else if (strobe) seen_strobe <= 1'b1;

      // vs_fall on the same cycle as hs_fall is consumed by that hs_fall.
      if (hs_fall) begin
        vs_pend <= 1'b0;
        if (vs_pend || vs_fall) y <= '0;
        else if (y != '1)       y <= y + 10'd1;
      end else if (vs_fall) begin
        vs_pend <= 1'b1;
      end

      if (state != MEASURE || y_clear) all_good <= 1'b1;
      else if (hs_fall && !line_good)  all_good <= 1'b0;

      if (lose && err_count != '1) err_count <= err_count + 8'd1;

      frame_start <= y_clear && (state_next == LOCKED);

      wr_en <= 1'b0;
      if (state == LOCKED && strobe && active && keep) begin
        wr_en   <= 1'b1;
        wr_addr <= addr;
        wr_data <= colour;
      end
    end
  end

  assign locked = (state == LOCKED);
  assign pix_x  = x;
  assign pix_y  = y;

endmodule
